// File: rtl/rpc_pkg.sv
// Shared definitions for the note record/playback controller: FSM states,
// button note codes and default parameter values.
package rpc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RECORD    = 2'd1,
        ST_PLAY_READ = 2'd2,
        ST_PLAY_HOLD = 2'd3
    } rpc_state_e;

    localparam logic [2:0] NOTE_B1 = 3'd1;
    localparam logic [2:0] NOTE_B2 = 3'd2;
    localparam logic [2:0] NOTE_B3 = 3'd3;
    localparam logic [2:0] NOTE_B4 = 3'd4;
    localparam logic [2:0] NOTE_B5 = 3'd5;

    localparam int DEF_ADDR_W     = 16;
    localparam int DEF_NOTE_W     = 8;
    localparam int DEF_MEM_DEPTH  = 65000;
    localparam int DEF_NOTE_TICKS = 1000;

endpackage

// File: rtl/btn_edge_enc.sv
// Button front end: 2-flop synchroniser, rising-edge detect and lowest-index
// priority encode of the five note buttons into a single press pulse + code.
module btn_edge_enc
    import rpc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] btn,
    output logic       press,
    output logic [2:0] code
);

    logic [4:0] sync1_q;
    logic [4:0] sync2_q;
    logic [4:0] prev_q;
    logic [1:0] prime_q;
    logic [4:0] rise;

    // Edges are masked until the synchroniser has flushed, so a button held
    // through reset must be released and pressed again to count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            prime_q <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            if (prime_q != 2'd3) prime_q <= prime_q + 2'd1;
        end
    end

    always_comb begin
        rise  = sync2_q & ~prev_q;
        press = (prime_q == 2'd3) && (rise != 5'd0);
        code  = 3'd0;
        if (rise[0])      code = NOTE_B1;
        else if (rise[1]) code = NOTE_B2;
        else if (rise[2]) code = NOTE_B3;
        else if (rise[3]) code = NOTE_B4;
        else if (rise[4]) code = NOTE_B5;
    end

endmodule

// File: rtl/record_playback_ctrl.sv
// Note recorder/player: records button notes into external memory, then plays
// them back one note per NOTE_TICKS cycles. Define REC_LOOP_EN for looped playback.
module record_playback_ctrl
    import rpc_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int NOTE_W     = DEF_NOTE_W,
    parameter int MEM_DEPTH  = DEF_MEM_DEPTH,
    parameter int NOTE_TICKS = DEF_NOTE_TICKS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        btn,
    input  logic              sw_rec,
    input  logic              play_start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [NOTE_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [NOTE_W-1:0] mem_rdata,
    output logic [NOTE_W-1:0] note_out,
    output logic              note_valid,
    output logic [ADDR_W-1:0] length,
    output logic              full,
    output logic              busy,
    output rpc_state_e        dbg_state_o
);

    localparam int TICK_W = (NOTE_TICKS > 1) ? $clog2(NOTE_TICKS) : 1;

    rpc_state_e        state_q;
    logic [ADDR_W-1:0] length_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [TICK_W-1:0] tick_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [NOTE_W-1:0] mem_wdata_q;
    logic              mem_we_q;
    logic [NOTE_W-1:0] note_out_q;
    logic              note_valid_q;

    logic              press;
    logic [2:0]        code;
    logic [ADDR_W:0]   rd_next;
    logic              full_w;

    btn_edge_enc u_btn (
        .clk   (clk),
        .reset (reset),
        .btn   (btn),
        .press (press),
        .code  (code)
    );

    assign rd_next = {1'b0, rd_ptr_q} + {{ADDR_W{1'b0}}, 1'b1};
    assign full_w  = (length_q == ADDR_W'(MEM_DEPTH));

    // note_valid is a plain qualifier with no back-pressure: note_out holds the
    // current note for every cycle note_valid is high; consumers just sample it.
    // The write pointer is the note count itself, so length_q addresses writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            length_q     <= '0;
            rd_ptr_q     <= '0;
            tick_q       <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            note_out_q   <= '0;
            note_valid_q <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    note_valid_q <= 1'b0;
                    if (sw_rec) begin
                        state_q  <= ST_RECORD;
                        length_q <= '0;
                    end else if (play_start && (length_q != '0)) begin
                        state_q    <= ST_PLAY_READ;
                        rd_ptr_q   <= '0;
                        mem_addr_q <= '0;
                    end
                end
                ST_RECORD: begin
                    if (!sw_rec) begin
                        state_q <= ST_IDLE;
                    end else if (press && !full_w) begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= length_q;
                        mem_wdata_q <= NOTE_W'(code);
                        length_q    <= length_q + 1'b1;
                    end
                end
                // Read data for the registered address is sampled on leaving this state.
                ST_PLAY_READ: begin
                    if (sw_rec) begin
                        state_q <= ST_IDLE;
                    end else begin
                        note_out_q   <= mem_rdata;
                        note_valid_q <= 1'b1;
                        tick_q       <= TICK_W'(NOTE_TICKS - 1);
                        state_q      <= ST_PLAY_HOLD;
                    end
                end
                ST_PLAY_HOLD: begin
                    if (sw_rec) begin
                        state_q      <= ST_IDLE;
                        note_valid_q <= 1'b0;
                    end else if (tick_q != '0) begin
                        tick_q <= tick_q - 1'b1;
                    end else begin
                        note_valid_q <= 1'b0;
                        if (rd_next < {1'b0, length_q}) begin
                            rd_ptr_q   <= rd_next[ADDR_W-1:0];
                            mem_addr_q <= rd_next[ADDR_W-1:0];
                            state_q    <= ST_PLAY_READ;
                        end else begin
`ifdef REC_LOOP_EN
                            rd_ptr_q   <= '0;
                            mem_addr_q <= '0;
                            state_q    <= ST_PLAY_READ;
`else
                            state_q    <= ST_IDLE;
`endif
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_we      = mem_we_q;
    assign note_out    = note_out_q;
    assign note_valid  = note_valid_q;
    assign length      = length_q;
    assign full        = full_w;
    assign busy        = (state_q != ST_IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_record_playback_ctrl.sv
// Directed + randomized bench for record_playback_ctrl with a queue-based note
// model and an external memory model; REC_LOOP_EN selects looped expectations.
module tb_record_playback_ctrl;
    import rpc_pkg::*;

    localparam int ADDR_W = 8;
    localparam int NOTE_W = 8;
    localparam int DEPTH  = 4;
    localparam int TICKS  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [4:0]        btn;
    logic              sw_rec;
    logic              play_start;
    logic [ADDR_W-1:0] mem_addr;
    logic [NOTE_W-1:0] mem_wdata;
    logic              mem_we;
    logic [NOTE_W-1:0] mem_rdata;
    logic [NOTE_W-1:0] note_out;
    logic              note_valid;
    logic [ADDR_W-1:0] length;
    logic              full;
    logic              busy;
    rpc_state_e        dbg_state;

    int total = 0;
    int bad   = 0;

    logic [NOTE_W-1:0] mem_arr [0:255];
    logic [7:0]        exp_q[$];
    logic [7:0]        exp_addr_q[$];
    logic [7:0]        model_q[$];
    int                rec_len = 0;

    record_playback_ctrl #(
        .ADDR_W     (ADDR_W),
        .NOTE_W     (NOTE_W),
        .MEM_DEPTH  (DEPTH),
        .NOTE_TICKS (TICKS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn         (btn),
        .sw_rec      (sw_rec),
        .play_start  (play_start),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_rdata   (mem_rdata),
        .note_out    (note_out),
        .note_valid  (note_valid),
        .length      (length),
        .full        (full),
        .busy        (busy),
        .dbg_state_o (dbg_state)
    );

    // clock / memory model
    always #5 clk = ~clk;

    always @(posedge clk) if (mem_we) mem_arr[mem_addr] <= mem_wdata;
    assign mem_rdata = mem_arr[mem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // write scoreboard
    always @(negedge clk) begin
        if (reset && mem_we) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_we", 32'(mem_we), 32'd0);
            end else begin
                chk("we_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
                chk("we_data", 32'(mem_wdata), 32'(exp_q.pop_front()));
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [4:0] mask);
        logic [7:0] code;
        code = 8'd0;
        for (int b = 4; b >= 0; b--) if (mask[b]) code = 8'(b + 1);
        if (rec_len < DEPTH) begin
            exp_q.push_back(code);
            exp_addr_q.push_back(8'(rec_len));
            model_q.push_back(code);
            rec_len++;
        end
        btn = mask;
        repeat (6) step();
        btn = 5'd0;
        repeat (6) step();
    endtask

    task automatic rec_begin();
        sw_rec = 1'b1;
        model_q.delete();
        rec_len = 0;
        step();
        step();
        chk("rec_busy", 32'(busy), 32'd1);
    endtask

    task automatic rec_end();
        sw_rec = 1'b0;
        step();
        step();
        chk("rec_length", 32'(length), 32'(rec_len));
        chk("rec_full", 32'(full), 32'(rec_len == DEPTH));
        chk("rec_idle", 32'(busy), 32'd0);
    endtask

    task automatic play_check(input int n_obs, input bit abort);
        logic [7:0] exp_note;
        play_start = 1'b1;
        step();
        play_start = 1'b0;
        chk("read_busy", 32'(busy), 32'd1);
        chk("read_valid", 32'(note_valid), 32'd0);
        step();
        for (int i = 0; i < n_obs; i++) begin
            exp_note = model_q[i % model_q.size()];
            for (int k = 0; k < TICKS; k++) begin
                if (abort && (i == n_obs - 1) && (k == 2)) begin
                    sw_rec = 1'b1;
                    step();
                    sw_rec = 1'b0;
                    chk("abort_busy", 32'(busy), 32'd0);
                    chk("abort_valid", 32'(note_valid), 32'd0);
                    return;
                end
                chk("hold_valid", 32'(note_valid), 32'd1);
                chk("hold_note", 32'(note_out), 32'(exp_note));
                step();
            end
            chk("gap_valid", 32'(note_valid), 32'd0);
            if (i == n_obs - 1) begin
                chk("end_busy", 32'(busy), 32'd0);
            end else begin
                chk("gap_busy", 32'(busy), 32'd1);
                step();
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_addr"},  32'(mem_addr),   32'd0);
        chk({tag, "_wdata"}, 32'(mem_wdata),  32'd0);
        chk({tag, "_we"},    32'(mem_we),     32'd0);
        chk({tag, "_note"},  32'(note_out),   32'd0);
        chk({tag, "_valid"}, 32'(note_valid), 32'd0);
        chk({tag, "_len"},   32'(length),     32'd0);
        chk({tag, "_full"},  32'(full),       32'd0);
        chk({tag, "_busy"},  32'(busy),       32'd0);
    endtask

    initial begin
        reset      = 1'b0;
        btn        = 5'd0;
        sw_rec     = 1'b0;
        play_start = 1'b0;
        repeat (3) step();
        chk_all_zero("reset");
        chk("reset_state", 32'(dbg_state), 32'(ST_IDLE));
        reset = 1'b1;
        repeat (4) step();

        // play request with nothing recorded stays idle
        play_start = 1'b1;
        step();
        play_start = 1'b0;
        chk("empty_play_busy", 32'(busy), 32'd0);
        step();
        chk("empty_play_busy2", 32'(busy), 32'd0);

        // record b3, b1, b5
        rec_begin();
        press(5'b00100);
        press(5'b00001);
        press(5'b10000);
        rec_end();
`ifdef REC_LOOP_EN
        play_check(5, 1'b1);
`else
        play_check(3, 1'b0);
`endif

        // simultaneous b2+b4, then random chords until past full
        rec_begin();
        press(5'b01010);
        for (int j = 0; j < 4; j++) press(5'($urandom_range(1, 31)));
        chk("full_in_rec", 32'(full), 32'd1);
        rec_end();
`ifdef REC_LOOP_EN
        play_check(6, 1'b1);
`else
        play_check(4, 1'b0);
`endif
        play_check(2, 1'b1);

        // asynchronous reset in the middle of a held note, button held through it
        play_start = 1'b1;
        step();
        play_start = 1'b0;
        step();
        chk("pre_reset_valid", 32'(note_valid), 32'd1);
        btn = 5'b00001;
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("async_reset");
        exp_q.delete();
        exp_addr_q.delete();
        model_q.delete();
        rec_len = 0;
        repeat (3) step();
        reset = 1'b1;
        step();

        // held button must not count as a press after reset
        rec_begin();
        repeat (8) step();
        chk("held_btn_len", 32'(length), 32'd0);
        btn = 5'd0;
        repeat (4) step();
        press(5'b00010);
        rec_end();

        chk("writes_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
